// File: rtl/deinterleaver_pkg.sv
// deinterleaver_pkg: shared width constants, the deinterleaver state type
// and a small field helper for the interleaved word format.
package deinterleaver_pkg;

   localparam int INPUT_DATA_BITWIDTH     = 32;
   localparam int QUANTIZATION_BITWIDTH   = 12;
   localparam int SCALING_FACTOR_BITWIDTH = 12;

   typedef enum logic [1:0] {
      UNSYNC = 2'd0,
      FILLER = 2'd1,
      SF     = 2'd2,
      CTRL   = 2'd3
   } deinterleaver_state_t;

   // Side-channel nibble carried in the top four bits of every non-comma word.
   function automatic logic [3:0] nibble_of(input logic [INPUT_DATA_BITWIDTH-1:0] w);
      return w[31:28];
   endfunction

endpackage

// File: rtl/deinterleaver_if.sv
// deinterleaver_if: link-receiver word stream in, recovered fields out.
// master = upstream driver / observer, slave = the deinterleaver itself.
interface deinterleaver_if;
   import deinterleaver_pkg::*;

   logic                                   comma;
   logic [INPUT_DATA_BITWIDTH-1:0]         interleavedData;
   logic [2*QUANTIZATION_BITWIDTH-1:0]     quantizedData;
   logic                                   commaOut;
   logic [7:0]                             commaPayload;
   logic [SCALING_FACTOR_BITWIDTH-1:0]     scalingFactorOut;
   logic                                   scalingFactorValid;
   logic [SCALING_FACTOR_BITWIDTH-1:0]     controlDataOut;
   logic                                   controlDataValid;
   logic                                   locked;
   logic                                   syncError;

   modport master (
      output comma, interleavedData,
      input  quantizedData, commaOut, commaPayload, scalingFactorOut,
             scalingFactorValid, controlDataOut, controlDataValid, locked, syncError
   );

   modport slave (
      input  comma, interleavedData,
      output quantizedData, commaOut, commaPayload, scalingFactorOut,
             scalingFactorValid, controlDataOut, controlDataValid, locked, syncError
   );

endinterface

// File: rtl/deinterleaver_nibble_assembler.sv
// nibble_assembler: collects three 4-bit nibbles MSB first into a 12-bit word.
// Only the two oldest nibbles are stored; the third is taken straight from the
// input so the completed word is available in the same cycle as done.
module nibble_assembler (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        shift,
   input  logic [3:0]  nibble,
   output logic [11:0] value,
   output logic        done
);

   logic [7:0] sr;
   logic [1:0] cnt;

   assign value = {sr, nibble};
   assign done  = shift && (cnt == 2'd2);

   // Shift in one nibble per enabled cycle; counter wraps 0..2, clear restarts.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         sr  <= '0;
         cnt <= '0;
      end else if (shift) begin
         sr  <= {sr[3:0], nibble};
         cnt <= done ? 2'd0 : cnt + 2'd1;
      end
   end

endmodule

// File: rtl/deinterleaver.sv
// deinterleaver: splits {I,Q} from each word and rebuilds the scaling factor
// and control words from the per-word nibbles, framed by comma words.
// Optional filler-nibble check: define DEINTERLEAVER_FILLER_CHECK_EN.
module deinterleaver
   import deinterleaver_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   deinterleaver_if.slave bus
);

   deinterleaver_state_t state;
   logic [3:0]           nib;
   logic                 asm_clear, asm_shift, asm_done;
   logic [11:0]          asm_value;

   assign nib       = nibble_of(bus.interleavedData);
   // A comma always restarts collection; groups only advance in SF/CTRL.
   assign asm_clear = bus.comma;
   assign asm_shift = !bus.comma && (state == SF || state == CTRL);

   nibble_assembler u_asm (
      .clk    (clk),
      .rst    (rst),
      .clear  (asm_clear),
      .shift  (asm_shift),
      .nibble (nib),
      .value  (asm_value),
      .done   (asm_done)
   );

`ifndef DEINTERLEAVER_FILLER_CHECK_EN
   assign bus.syncError = 1'b0;
`endif

   // Frame FSM plus all registered outputs; comma beats any group completion.
   always_ff @(posedge clk) begin
      if (rst) begin
         state                  <= UNSYNC;
         bus.quantizedData      <= '0;
         bus.commaOut           <= 1'b0;
         bus.commaPayload       <= '0;
         bus.scalingFactorOut   <= '0;
         bus.scalingFactorValid <= 1'b0;
         bus.controlDataOut     <= '0;
         bus.controlDataValid   <= 1'b0;
         bus.locked             <= 1'b0;
`ifdef DEINTERLEAVER_FILLER_CHECK_EN
         bus.syncError          <= 1'b0;
`endif
      end else begin
         bus.quantizedData      <= {bus.interleavedData[27:16], bus.interleavedData[11:0]};
         bus.commaOut           <= bus.comma;
         bus.scalingFactorValid <= 1'b0;
         bus.controlDataValid   <= 1'b0;
`ifdef DEINTERLEAVER_FILLER_CHECK_EN
         bus.syncError          <= 1'b0;
`endif
         if (bus.comma) begin
            state            <= FILLER;
            bus.locked       <= 1'b1;
            bus.commaPayload <= {bus.interleavedData[31:28], bus.interleavedData[15:12]};
         end else begin
            case (state)
               UNSYNC: state <= UNSYNC;
               FILLER: begin
`ifdef DEINTERLEAVER_FILLER_CHECK_EN
                  if (nib != 4'h0) begin
                     bus.syncError <= 1'b1;
                     bus.locked    <= 1'b0;
                     state         <= UNSYNC;
                  end else begin
                     state <= SF;
                  end
`else
                  state <= SF;
`endif
               end
               SF: if (asm_done) begin
                  bus.scalingFactorOut   <= asm_value;
                  bus.scalingFactorValid <= 1'b1;
                  state                  <= CTRL;
               end
               CTRL: if (asm_done) begin
                  bus.controlDataOut   <= asm_value;
                  bus.controlDataValid <= 1'b1;
               end
               default: state <= UNSYNC;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_deinterleaver.sv
// tb_deinterleaver: directed frames with hand-computed expectations.
module tb_deinterleaver;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   npass = 0;
   int   ntot  = 0;

   deinterleaver_if bus();

   deinterleaver dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntot++;
      if (obs === exp) npass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Apply one word for one cycle, then sample just after the edge.
   task automatic step(input logic r, input logic c, input logic [31:0] d);
      @(negedge clk);
      rst = r;
      bus.comma = c;
      bus.interleavedData = d;
      @(posedge clk);
      #1;
   endtask

   task automatic nib(input logic [3:0] n);
      step(1'b0, 1'b0, {n, 28'h0ABCDEF});
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_qd"},  {8'h0, bus.quantizedData}, 32'h0);
      chk({tag, "_co"},  {31'h0, bus.commaOut}, 32'h0);
      chk({tag, "_cp"},  {24'h0, bus.commaPayload}, 32'h0);
      chk({tag, "_sf"},  {20'h0, bus.scalingFactorOut}, 32'h0);
      chk({tag, "_sfv"}, {31'h0, bus.scalingFactorValid}, 32'h0);
      chk({tag, "_cd"},  {20'h0, bus.controlDataOut}, 32'h0);
      chk({tag, "_cdv"}, {31'h0, bus.controlDataValid}, 32'h0);
      chk({tag, "_lk"},  {31'h0, bus.locked}, 32'h0);
      chk({tag, "_se"},  {31'h0, bus.syncError}, 32'h0);
   endtask

   initial begin
      bus.comma = 1'b0;
      bus.interleavedData = 32'h0;

      // Reset with a live comma on the bus: reset must win.
      step(1'b1, 1'b1, 32'hFFFF_FFFF);
      step(1'b1, 1'b1, 32'hFFFF_FFFF);
      chk_all_zero("reset");

      // Unsynchronised: data passes through, no lock, no pulses.
      step(1'b0, 1'b0, 32'h1234_5678);
      chk("unsync_qd0", {8'h0, bus.quantizedData}, 32'h0023_4678);
      step(1'b0, 1'b0, 32'hF0F0_0F0F);
      chk("unsync_qd1", {8'h0, bus.quantizedData}, 32'h000F_0F0F);
      chk("unsync_lk",  {31'h0, bus.locked}, 32'h0);
      step(1'b0, 1'b0, 32'h5000_0000);
      step(1'b0, 1'b0, 32'hC000_0000);
      step(1'b0, 1'b0, 32'h3000_0000);
      chk("unsync_sfv", {31'h0, bus.scalingFactorValid}, 32'h0);
      chk("unsync_cdv", {31'h0, bus.controlDataValid}, 32'h0);

      // Frame: comma, filler, SF 5C3, control 123 and F0E.
      step(1'b0, 1'b1, 32'hA123_B456);
      chk("c1_qd", {8'h0, bus.quantizedData}, 32'h0012_3456);
      chk("c1_co", {31'h0, bus.commaOut}, 32'h1);
      chk("c1_cp", {24'h0, bus.commaPayload}, 32'h0000_00AB);
      chk("c1_lk", {31'h0, bus.locked}, 32'h1);
      nib(4'h0);
      chk("fill_co", {31'h0, bus.commaOut}, 32'h0);
      nib(4'h5);
      nib(4'hC);
      chk("sf_early", {31'h0, bus.scalingFactorValid}, 32'h0);
      nib(4'h3);
      chk("sf1_v", {31'h0, bus.scalingFactorValid}, 32'h1);
      chk("sf1",   {20'h0, bus.scalingFactorOut}, 32'h5C3);
      nib(4'h1);
      chk("sf1_pulse", {31'h0, bus.scalingFactorValid}, 32'h0);
      nib(4'h2);
      nib(4'h3);
      chk("cd1_v", {31'h0, bus.controlDataValid}, 32'h1);
      chk("cd1",   {20'h0, bus.controlDataOut}, 32'h123);
      nib(4'hF);
      chk("cd_gap0", {31'h0, bus.controlDataValid}, 32'h0);
      nib(4'h0);
      chk("cd_gap1", {31'h0, bus.controlDataValid}, 32'h0);
      nib(4'hE);
      chk("cd2_v", {31'h0, bus.controlDataValid}, 32'h1);
      chk("cd2",   {20'h0, bus.controlDataOut}, 32'hF0E);
      chk("sf_held", {20'h0, bus.scalingFactorOut}, 32'h5C3);

      // Comma replaces the third nibble of a group: no pulse, new frame decodes.
      nib(4'h7);
      nib(4'h7);
      step(1'b0, 1'b1, 32'h5000_7000);
      chk("cut_cdv", {31'h0, bus.controlDataValid}, 32'h0);
      chk("cut_cp",  {24'h0, bus.commaPayload}, 32'h57);
      chk("cut_cd",  {20'h0, bus.controlDataOut}, 32'hF0E);
      nib(4'h0);
      nib(4'h9);
      nib(4'h8);
      nib(4'h7);
      chk("sf2_v", {31'h0, bus.scalingFactorValid}, 32'h1);
      chk("sf2",   {20'h0, bus.scalingFactorOut}, 32'h987);

      // Back-to-back commas: second one restarts the frame.
      step(1'b0, 1'b1, 32'h1000_2000);
      step(1'b0, 1'b1, 32'h3000_4000);
      chk("b2b_cp", {24'h0, bus.commaPayload}, 32'h34);
      nib(4'h0);
      nib(4'h6);
      nib(4'hA);
      nib(4'hB);
      chk("sf3_v", {31'h0, bus.scalingFactorValid}, 32'h1);
      chk("sf3",   {20'h0, bus.scalingFactorOut}, 32'h6AB);

      // Reset in SF after one nibble, then a clean frame.
      step(1'b0, 1'b1, 32'h2000_3000);
      nib(4'h0);
      nib(4'h1);
      step(1'b1, 1'b0, 32'h2000_0000);
      chk_all_zero("midrst");
      step(1'b0, 1'b1, 32'hC000_D000);
      nib(4'h0);
      nib(4'h4);
      nib(4'hD);
      nib(4'h2);
      chk("sf4_v", {31'h0, bus.scalingFactorValid}, 32'h1);
      chk("sf4",   {20'h0, bus.scalingFactorOut}, 32'h4D2);
      chk("sf4_lk", {31'h0, bus.locked}, 32'h1);

      // Non-zero filler nibble.
      step(1'b0, 1'b1, 32'h0000_0000);
      nib(4'h7);
`ifdef DEINTERLEAVER_FILLER_CHECK_EN
      chk("fchk_se", {31'h0, bus.syncError}, 32'h1);
      chk("fchk_lk", {31'h0, bus.locked}, 32'h0);
      nib(4'h1);
      chk("fchk_se_pulse", {31'h0, bus.syncError}, 32'h0);
      nib(4'h2);
      nib(4'h3);
      chk("fchk_sfv", {31'h0, bus.scalingFactorValid}, 32'h0);
      chk("fchk_sf",  {20'h0, bus.scalingFactorOut}, 32'h4D2);
      step(1'b0, 1'b1, 32'h0000_0000);
      nib(4'h0);
      nib(4'h8);
      nib(4'h1);
      nib(4'h5);
      chk("fchk_sf5", {20'h0, bus.scalingFactorOut}, 32'h815);
      chk("fchk_lk2", {31'h0, bus.locked}, 32'h1);
`else
      chk("fign_se", {31'h0, bus.syncError}, 32'h0);
      nib(4'h8);
      nib(4'h1);
      nib(4'h5);
      chk("fign_sfv", {31'h0, bus.scalingFactorValid}, 32'h1);
      chk("fign_sf",  {20'h0, bus.scalingFactorOut}, 32'h815);
      chk("fign_lk",  {31'h0, bus.locked}, 32'h1);
`endif

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
